// File: rtl/tri_bus_poller_if.sv
// Bus-side signal bundle for tri_bus_poller: sweep control, tri-state enables,
// captured bus value and the consumer valid/ready handshake.
interface tri_bus_poller_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic          iStart;
    logic [N-1:0]  iMask;
    logic [W-1:0]  iBus;
    logic          iReady;
    logic [N-1:0]  oEna;
    logic [W-1:0]  oData;
    logic [SW-1:0] oSrc;
    logic          oValid;
    logic          oBusy;
    logic          oDone;

    modport master (
        input  iStart, iMask, iBus, iReady,
        output oEna, oData, oSrc, oValid, oBusy, oDone
    );

    modport slave (
        output iStart, iMask, iBus, iReady,
        input  oEna, oData, oSrc, oValid, oBusy, oDone
    );
endinterface

// File: rtl/tri_bus_poller.sv
// Sweeps masked tri-state sources in ascending order, one enable at a time.
// Optional macro TURNAROUND_EN adds a one-cycle all-enables-low TURN after each handshake.
module tri_bus_poller #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int SETTLE = 2
) (
    input  logic               iClk,
    input  logic               iRst_n,
    tri_bus_poller_if.master   bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef TURNAROUND_EN
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_HOLD, S_TURN, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_HOLD, S_DONE} state_t;
`endif

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_pend;
    logic [SW-1:0] r_sel;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_ena;
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_src;

    logic [N-1:0]  w_cand;
    logic [SW-1:0] w_low_idx;
    logic          w_any;
    logic          w_launch;
    logic          w_capture;

    // In IDLE the mask has not been latched yet, so pick from the live input.
    assign w_cand = (r_state == S_IDLE) ? bus.iMask : r_pend;
    assign w_any  = |w_cand;

    always_comb begin
        w_low_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_cand[i]) w_low_idx = SW'(i);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iStart) begin
                    w_launch    = w_any;
                    w_state_nxt = w_any ? S_DRIVE : S_DONE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == CW'(SETTLE - 1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.iReady) begin
`ifdef TURNAROUND_EN
                    w_state_nxt = S_TURN;
`else
                    w_launch    = w_any;
                    w_state_nxt = w_any ? S_DRIVE : S_DONE;
`endif
                end
            end
`ifdef TURNAROUND_EN
            S_TURN: begin
                w_launch    = w_any;
                w_state_nxt = w_any ? S_DRIVE : S_DONE;
            end
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Enables are registered so the gates see a clean, glitch-free one-hot.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_pend <= '0;
            r_sel  <= '0;
            r_cnt  <= '0;
            r_ena  <= '0;
            r_data <= '0;
            r_src  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.iStart)
                r_pend <= bus.iMask;
            if (w_launch) begin
                r_sel <= w_low_idx;
                r_ena <= {{(N-1){1'b0}}, 1'b1} << w_low_idx;
                r_cnt <= '0;
            end else if (r_state == S_DRIVE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_capture) begin
                r_data        <= bus.iBus;
                r_src         <= r_sel;
                r_pend[r_sel] <= 1'b0;
                r_ena         <= '0;
            end
            if (r_state == S_DONE) begin
                r_data <= '0;
                r_src  <= '0;
            end
        end
    end

    assign bus.oEna   = r_ena;
    assign bus.oData  = r_data;
    assign bus.oSrc   = r_src;
    assign bus.oValid = (r_state == S_HOLD);
    assign bus.oBusy  = (r_state != S_IDLE);
    assign bus.oDone  = (r_state == S_DONE);
endmodule

// File: tb/tb_tri_bus_poller.sv
// Scoreboard bench for tri_bus_poller: random driver values, masks and consumer
// backpressure, plus directed reset, empty-mask, ignored-start and gap checks.
module tb_tri_bus_poller;
    localparam int N      = 4;
    localparam int W      = 8;
    localparam int SETTLE = 2;
    localparam int SW     = (N > 1) ? $clog2(N) : 1;
`ifdef TURNAROUND_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } beat_t;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    always #5 iClk = ~iClk;

    tri_bus_poller_if #(.N(N), .W(W)) ifc ();

    tri_bus_poller #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (ifc)
    );

    logic [W-1:0] drv [N];
    beat_t        sb [$];
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           done_base = 0;
    int           rdy_mode = 0;

    // Behavioural tri-state bus: every enabled driver contributes its value.
    always_comb begin
        ifc.iBus = '0;
        for (int i = 0; i < N; i++)
            if (ifc.oEna[i]) ifc.iBus = ifc.iBus | drv[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        ifc.iReady = 1'b1;
        forever begin
            @(posedge iClk);
            #1;
            case (rdy_mode)
                0:       ifc.iReady = 1'b1;
                1:       ifc.iReady = 1'b0;
                default: ifc.iReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected beats on each handshake and checks bus invariants.
    logic [N-1:0]  prev_ena;
    logic          prev_valid, prev_ready, prev_done;
    logic [W-1:0]  prev_data;
    logic [SW-1:0] prev_src;
    always @(negedge iClk) begin
        if (!iRst_n) begin
            prev_ena = '0; prev_valid = 0; prev_ready = 0; prev_done = 0;
            prev_data = '0; prev_src = '0;
        end else begin
            chk("ena_onehot", 32'($countones(ifc.oEna) <= 1), 1);
            if (prev_ena != 0 && ifc.oEna != 0)
                chk("ena_no_direct_switch", 32'(ifc.oEna), 32'(prev_ena));
            if (ifc.oValid) begin
                chk("ena_low_while_valid", 32'(ifc.oEna), 0);
                if (prev_valid && !prev_ready) begin
                    chk("hold_data_stable", 32'(ifc.oData), 32'(prev_data));
                    chk("hold_src_stable", 32'(ifc.oSrc), 32'(prev_src));
                end
                if (ifc.iReady) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 32'({ifc.oSrc, ifc.oData}), 32'hFFFFFFFF);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("beat_src", 32'(ifc.oSrc), 32'(e.src));
                        chk("beat_data", 32'(ifc.oData), 32'(e.data));
                    end
                end
            end
            if (ifc.oDone) begin
                done_cnt++;
                chk("done_single_cycle", 32'(prev_done), 0);
            end
            prev_ena = ifc.oEna; prev_valid = ifc.oValid; prev_ready = ifc.iReady;
            prev_done = ifc.oDone; prev_data = ifc.oData; prev_src = ifc.oSrc;
        end
    end

    task automatic start_sweep(input logic [N-1:0] mask);
        done_base = done_cnt;
        for (int i = 0; i < N; i++)
            if (mask[i]) sb.push_back('{src: SW'(i), data: drv[i]});
        @(posedge iClk); #1;
        ifc.iStart = 1'b1;
        ifc.iMask  = mask;
        @(posedge iClk); #1;
        ifc.iStart = 1'b0;
        ifc.iMask  = N'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(posedge iClk);
            n++;
        end
        chk("done_seen", 32'(done_cnt != done_base), 1);
        @(negedge iClk);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("done_once", 32'(done_cnt - done_base), 1);
    endtask

    task automatic rand_drv();
        for (int i = 0; i < N; i++) drv[i] = W'($urandom);
    endtask

    initial begin
        logic [N-1:0] eh [64];
        logic         vh [64];
        int           idx, n1, gap, n2, fv;
        logic         found;

        ifc.iStart = 1'b0;
        ifc.iMask  = '0;
        for (int i = 0; i < N; i++) drv[i] = W'(8'hA0 + i);

        // Reset state
        repeat (3) @(negedge iClk);
        chk("rst_ena", 32'(ifc.oEna), 0);
        chk("rst_valid", 32'(ifc.oValid), 0);
        chk("rst_busy", 32'(ifc.oBusy), 0);
        chk("rst_done", 32'(ifc.oDone), 0);
        chk("rst_data", 32'(ifc.oData), 0);
        iRst_n = 1'b1;
        repeat (2) @(negedge iClk);

        // Full sweep with fixed driver values
        rdy_mode = 0;
        start_sweep(4'b1011);
        wait_done();
        @(negedge iClk);
        chk("idle_after_sweep_busy", 32'(ifc.oBusy), 0);
        chk("idle_after_sweep_data", 32'(ifc.oData), 0);

        // Gap and latency between two adjacent sources
        rand_drv();
        start_sweep(4'b0011);
        for (int c = 0; c < 64; c++) begin
            @(negedge iClk);
            eh[c] = ifc.oEna;
            vh[c] = ifc.oValid;
        end
        idx = 0; n1 = 0; gap = 0; n2 = 0; fv = -1;
        while (idx < 64 && eh[idx] == 4'b0001) begin n1++; idx++; end
        while (idx < 64 && eh[idx] == 4'b0000) begin gap++; idx++; end
        while (idx < 64 && eh[idx] == 4'b0010) begin n2++; idx++; end
        for (int c = 63; c >= 0; c--) if (vh[c]) fv = c;
        chk("drive_len_src0", 32'(n1), SETTLE);
        chk("bus_idle_gap", 32'(gap), GAP);
        chk("drive_len_src1", 32'(n2), SETTLE);
        chk("valid_latency", 32'(fv), SETTLE);
        wait_done();

        // Empty mask
        start_sweep('0);
        @(negedge iClk);
        chk("empty_done", 32'(ifc.oDone), 1);
        chk("empty_valid", 32'(ifc.oValid), 0);
        chk("empty_ena", 32'(ifc.oEna), 0);
        @(negedge iClk);
        chk("empty_idle", 32'(ifc.oBusy), 0);
        chk("empty_done_count", 32'(done_cnt - done_base), 1);

        // Backpressure on a single source
        rand_drv();
        rdy_mode = 1;
        start_sweep(4'b0001);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge iClk);
            found = ifc.oValid;
        end
        chk("bp_valid_rose", 32'(found), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge iClk);
            chk("bp_valid_held", 32'(ifc.oValid), 1);
            chk("bp_data_held", 32'(ifc.oData), 32'(drv[0]));
            chk("bp_ena_low", 32'(ifc.oEna), 0);
        end
        rdy_mode = 0;
        wait_done();

        // Second start mid-sweep must be ignored
        rand_drv();
        rdy_mode = 2;
        start_sweep(4'b1111);
        repeat (3) @(posedge iClk);
        #1; ifc.iStart = 1'b1; ifc.iMask = 4'b0001;
        @(posedge iClk); #1; ifc.iStart = 1'b0;
        wait_done();
        repeat (10) @(negedge iClk);
        chk("no_restart", 32'(done_cnt - done_base), 1);

        // Randomized sweeps under random backpressure
        for (int t = 0; t < 12; t++) begin
            rand_drv();
            start_sweep(N'($urandom));
            wait_done();
        end

        // Asynchronous reset mid-DRIVE
        rdy_mode = 0;
        rand_drv();
        start_sweep(4'b0100);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge iClk);
            found = (ifc.oEna == 4'b0100);
        end
        chk("rst_mid_drive_reached", 32'(found), 1);
        #2 iRst_n = 1'b0;
        #1 chk("rst_async_ena", 32'(ifc.oEna), 0);
        sb.delete();
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        chk("post_rst_ena", 32'(ifc.oEna), 0);
        chk("post_rst_data", 32'(ifc.oData), 0);
        chk("post_rst_src", 32'(ifc.oSrc), 0);
        chk("post_rst_valid", 32'(ifc.oValid), 0);
        chk("post_rst_busy", 32'(ifc.oBusy), 0);
        chk("post_rst_done", 32'(ifc.oDone), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
